// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic instruction commands into 32-bit MIPS machine
// words and writes them sequentially into instruction memory through a
// valid/ready write port. Used to fill imem before the core leaves reset.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_kind,
  input  logic [4:0]  cmd_rs,
  input  logic [4:0]  cmd_rt,
  input  logic [4:0]  cmd_rd,
  input  logic [15:0] cmd_imm,
  input  logic [25:0] cmd_target,
  input  logic        cmd_last,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [15:0] count,
  output logic        err,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Command kinds as presented on cmd_kind.
  localparam logic [3:0] K_NOP  = 4'd0;
  localparam logic [3:0] K_ADD  = 4'd1;
  localparam logic [3:0] K_SUB  = 4'd2;
  localparam logic [3:0] K_AND  = 4'd3;
  localparam logic [3:0] K_OR   = 4'd4;
  localparam logic [3:0] K_SLT  = 4'd5;
  localparam logic [3:0] K_LW   = 4'd6;
  localparam logic [3:0] K_SW   = 4'd7;
  localparam logic [3:0] K_BEQ  = 4'd8;
  localparam logic [3:0] K_ADDI = 4'd9;
  localparam logic [3:0] K_J    = 4'd10;

  // Opcode / funct values the control decoder expects.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // Highest word address in imem; one step past it wraps back to BASE_ADDR.
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

  state_t      r_state;
  logic        r_cmd_ready;
  logic        r_wr_valid;
  logic [31:0] r_addr;
  logic [31:0] r_wr_data;
  logic [15:0] r_count;
  logic        r_err;
  logic        r_done;
  logic        r_last;

  logic [31:0] w_enc;
  logic        w_legal;
  logic [31:0] w_next_addr;

  // Combinational encoder: build the machine word for the presented command.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    w_enc   = 32'h0000_0000;
    w_legal = 1'b1;
    case (cmd_kind)
      K_NOP:  w_enc = 32'h0000_0000;
      K_ADD:  w_enc = {OP_RTYPE, cmd_rs, cmd_rt, cmd_rd, 5'd0, FN_ADD};
      K_SUB:  w_enc = {OP_RTYPE, cmd_rs, cmd_rt, cmd_rd, 5'd0, FN_SUB};
      K_AND:  w_enc = {OP_RTYPE, cmd_rs, cmd_rt, cmd_rd, 5'd0, FN_AND};
      K_OR:   w_enc = {OP_RTYPE, cmd_rs, cmd_rt, cmd_rd, 5'd0, FN_OR};
      K_SLT:  w_enc = {OP_RTYPE, cmd_rs, cmd_rt, cmd_rd, 5'd0, FN_SLT};
      K_LW:   w_enc = {OP_LW,   cmd_rs, cmd_rt, cmd_imm};
      K_SW:   w_enc = {OP_SW,   cmd_rs, cmd_rt, cmd_imm};
      K_BEQ:  w_enc = {OP_BEQ,  cmd_rs, cmd_rt, cmd_imm};
      K_ADDI: w_enc = {OP_ADDI, cmd_rs, cmd_rt, cmd_imm};
      K_J:    w_enc = {OP_J,    cmd_target};
      default: w_legal = 1'b0;
    endcase
  end

  // Next write address, wrapping at the end of imem.
  always_comb begin
    w_next_addr = (r_addr == LAST_ADDR) ? BASE_ADDR : r_addr + 32'd4;
  end

  // Loader FSM: accept a command, hold the write until imem takes it, stop
  // permanently once the last word (or an illegal last command) is seen.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_wr_valid  <= 1'b0;
      r_addr      <= BASE_ADDR;
      r_wr_data   <= 32'h0000_0000;
      r_count     <= 16'd0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            if (w_legal) begin
              r_wr_data   <= w_enc;
              r_last      <= cmd_last;
              r_state     <= WRITE;
              r_cmd_ready <= 1'b0;
              r_wr_valid  <= 1'b1;
            end else begin
              // Illegal kinds are consumed without a write.
              r_err <= 1'b1;
              if (cmd_last) begin
                r_done      <= 1'b1;
                r_state     <= DONE;
                r_cmd_ready <= 1'b0;
              end
            end
          end
        end
        WRITE: begin
          if (wr_ready) begin
            r_addr     <= w_next_addr;
            r_wr_valid <= 1'b0;
            if (r_count != 16'hFFFF) begin
              r_count <= r_count + 16'd1;
            end
            if (r_last) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state     <= IDLE;
              r_cmd_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          r_cmd_ready <= 1'b0;
          r_wr_valid  <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
          r_wr_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign wr_valid  = r_wr_valid;
  assign wr_addr   = r_addr;
  assign wr_data   = r_wr_data;
  assign count     = r_count;
  assign err       = r_err;
  assign done      = r_done;

endmodule
